// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding sources, fetch redirect/stall and the EX/MEM register
// outputs of the execute stage, bundled for the pipeline top level.
interface execute_stage_if;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [31:0] rs1E, rs2E, ImmExtE, PCE, inc_PCE;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUoutM, rs2M, inc_PCM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;

  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE,
           ResultSrcE, ALUControlE, funct3E, rs1E, rs2E, ImmExtE, PCE, inc_PCE,
           RdE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
           ALUoutM, rs2M, inc_PCM, funct3M, RdM
  );

  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE,
           ResultSrcE, ALUControlE, funct3E, rs1E, rs2E, ImmExtE, PCE, inc_PCE,
           RdE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
           ALUoutM, rs2M, inc_PCM, funct3M, RdM
  );
endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: forwarding, ALU, branch resolution, single-cycle multiply,
// 32-step restoring divider that stalls the front end, and the EX/MEM register.
module execute_stage (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave ex
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} div_state_t;

  div_state_t state_p0, state_nxt;
  logic [4:0] cnt_p0;
  logic       div_req, div_load, div_step, stall;

  logic signed [DATA_W-1:0] srca, wdata, srcb, alu_res, mul_res, div_res, ex_res;
  logic [DATA_W-1:0] quo_p0, rem_p0, dvs_p0;
  logic              qneg_p0, rneg_p0, remsel_p0;
  logic [DATA_W:0]   rem_sh, rem_diff;
  logic              div_sgn, br_cond;

  logic              regwrite_p1, memwrite_p1;
  logic [1:0]        resultsrc_p1;
  logic [DATA_W-1:0] aluout_p1, rs2_p1, incpc_p1;
  logic [2:0]        funct3_p1;
  logic [4:0]        rd_p1;

  function automatic logic [DATA_W-1:0] fwd(input logic [DATA_W-1:0] reg_v,
                                            input logic [1:0] sel,
                                            input logic [DATA_W-1:0] res_w,
                                            input logic [DATA_W-1:0] alu_m);
    case (sel)
      2'b01:   return res_w;
      2'b10:   return alu_m;
      default: return reg_v;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] alu_op(input logic [3:0] ctl,
                                                      input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (ctl)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = a << b[4:0];
      4'b0110: r = $signed($unsigned(a) >> b[4:0]);
      4'b0111: r = a >>> b[4:0];
      4'b1000: r = {{(DATA_W-1){1'b0}}, (a < b)};
      4'b1001: r = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      4'b1010: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Operands are widened by one bit so one signed multiplier covers all four variants.
  function automatic logic signed [DATA_W-1:0] mul_op(input logic [2:0] f3,
                                                      input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0]     ma, mb;
    logic signed [2*DATA_W-1:0] prod;
    ma   = {(f3[1:0] != 2'b11) & a[DATA_W-1], a};
    mb   = {~f3[1] & b[DATA_W-1], b};
    prod = 64'(ma) * 64'(mb);
    return (f3[1:0] == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic branch_op(input logic [2:0] f3,
                                     input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return a < b;
      3'b101:  return a >= b;
      3'b110:  return $unsigned(a) < $unsigned(b);
      3'b111:  return $unsigned(a) >= $unsigned(b);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    srca    = fwd(ex.rs1E, ex.ForwardAE, ex.ResultW, aluout_p1);
    wdata   = fwd(ex.rs2E, ex.ForwardBE, ex.ResultW, aluout_p1);
    srcb    = ex.ALUSrcE ? ex.ImmExtE : wdata;
    alu_res = alu_op(ex.ALUControlE, srca, srcb);
    mul_res = mul_op(ex.funct3E, srca, wdata);
    br_cond = branch_op(ex.funct3E, srca, wdata);
    div_res = remsel_p0 ? (rneg_p0 ? -rem_p0 : rem_p0) : (qneg_p0 ? -quo_p0 : quo_p0);
    ex_res  = ex.MulDivE ? (ex.funct3E[2] ? div_res : mul_res) : alu_res;
  end

  assign ex.PCSrcE    = ~stall & (ex.JumpE | (ex.BranchE & br_cond));
  assign ex.PCTargetE = ex.JalrE ? ((srca + ex.ImmExtE) & ~32'd1) : (ex.PCE + ex.ImmExtE);
  assign ex.StallE    = stall;

  // Divider FSM: state register, next state, outputs.
  always_ff @(posedge clk) begin
    if (rst) state_p0 <= IDLE;
    else     state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (div_req) state_nxt = DIV;
      DIV:     if (cnt_p0 == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_req  = ex.MulDivE & ex.funct3E[2];
    div_load = (state_p0 == IDLE) & div_req;
    div_step = (state_p0 == DIV);
    stall    = div_load | div_step;
  end

  always_ff @(posedge clk) begin
    if (rst)           cnt_p0 <= '0;
    else if (div_load) cnt_p0 <= '0;
    else if (div_step) cnt_p0 <= cnt_p0 + 5'd1;
  end

  // Restoring division on magnitudes; signs are reapplied when the result is read.
  always_comb begin
    div_sgn  = ~ex.funct3E[0];
    rem_sh   = {rem_p0, quo_p0[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, dvs_p0};
  end

  always_ff @(posedge clk) begin
    if (div_load) begin
      quo_p0    <= (div_sgn && srca[DATA_W-1])  ? -srca  : srca;
      dvs_p0    <= (div_sgn && wdata[DATA_W-1]) ? -wdata : wdata;
      rem_p0    <= '0;
      qneg_p0   <= div_sgn & (srca[DATA_W-1] ^ wdata[DATA_W-1]) & (wdata != '0);
      rneg_p0   <= div_sgn & srca[DATA_W-1];
      remsel_p0 <= ex.funct3E[1];
    end else if (div_step) begin
      if (!rem_diff[DATA_W]) begin
        rem_p0 <= rem_diff[DATA_W-1:0];
        quo_p0 <= {quo_p0[DATA_W-2:0], 1'b1};
      end else begin
        rem_p0 <= rem_sh[DATA_W-1:0];
        quo_p0 <= {quo_p0[DATA_W-2:0], 1'b0};
      end
    end
  end

  // EX/MEM register boundary.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      regwrite_p1  <= 1'b0;
      memwrite_p1  <= 1'b0;
      resultsrc_p1 <= '0;
      aluout_p1    <= '0;
      rs2_p1       <= '0;
      incpc_p1     <= '0;
      funct3_p1    <= '0;
      rd_p1        <= '0;
    end else begin
      regwrite_p1  <= ex.RegWriteE;
      memwrite_p1  <= ex.MemWriteE;
      resultsrc_p1 <= ex.ResultSrcE;
      aluout_p1    <= ex_res;
      rs2_p1       <= wdata;
      incpc_p1     <= ex.inc_PCE;
      funct3_p1    <= ex.funct3E;
      rd_p1        <= ex.RdE;
    end
  end

  assign ex.RegWriteM  = regwrite_p1;
  assign ex.MemWriteM  = memwrite_p1;
  assign ex.ResultSrcM = resultsrc_p1;
  assign ex.ALUoutM    = aluout_p1;
  assign ex.rs2M       = rs2_p1;
  assign ex.inc_PCM    = incpc_p1;
  assign ex.funct3M    = funct3_p1;
  assign ex.RdM        = rd_p1;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases plus randomized instructions
// against an arithmetic reference model; a monitor compares the EX/MEM register.
`timescale 1ns/1ps
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_if ex();
  execute_stage dut (.clk(clk), .rst(rst), .ex(ex));

  typedef struct packed {
    logic        rw, mw;
    logic [1:0]  rsrc;
    logic [31:0] alu, rs2, inc;
    logic [2:0]  f3;
    logic [4:0]  rd;
  } mrec_t;

  typedef struct packed {
    logic        rw, mw, jump, branch, jalr, alusrc, muldiv;
    logic [1:0]  rsrc;
    logic [3:0]  aluc;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    logic [31:0] resw;
  } instr_t;

  mrec_t       exp_q[$];
  mrec_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_alu;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected EX/MEM record per captured cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        #1;
        check32("RegWriteM",  {31'b0, ex.RegWriteM}, {31'b0, mon_e.rw});
        check32("MemWriteM",  {31'b0, ex.MemWriteM}, {31'b0, mon_e.mw});
        check32("ResultSrcM", {30'b0, ex.ResultSrcM}, {30'b0, mon_e.rsrc});
        check32("ALUoutM",    ex.ALUoutM, mon_e.alu);
        check32("rs2M",       ex.rs2M, mon_e.rs2);
        check32("inc_PCM",    ex.inc_PCM, mon_e.inc);
        check32("funct3M",    {29'b0, ex.funct3M}, {29'b0, mon_e.f3});
        check32("RdM",        {27'b0, ex.RdM}, {27'b0, mon_e.rd});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fwd(input logic [31:0] r, input logic [1:0] s,
                                          input logic [31:0] w, input logic [31:0] m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << (b % 32);
      4'd6:  return a >> (b % 32);
      4'd7:  return sa >>> (b % 32);
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    longint unsigned pu;
    sa = a;
    sb = b;
    case (f3[1:0])
      2'b00:   begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      2'b01:   begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      2'b10:   begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      default: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic logic [32:0] ref_branch(input instr_t in, input logic [31:0] a, input logic [31:0] b);
    int   sa, sb;
    logic cond;
    logic [31:0] tgt;
    sa = a;
    sb = b;
    case (in.f3)
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = (sa < sb);
      3'b101:  cond = (sa >= sb);
      3'b110:  cond = (a < b);
      3'b111:  cond = (a >= b);
      default: cond = 1'b0;
    endcase
    tgt = in.jalr ? ((a + in.imm) & 32'hFFFF_FFFE) : (in.pc + in.imm);
    return {in.jump | (in.branch & cond), tgt};
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input instr_t in);
    rst            = 1'b0;
    ex.RegWriteE   = in.rw;
    ex.MemWriteE   = in.mw;
    ex.JumpE       = in.jump;
    ex.BranchE     = in.branch;
    ex.JalrE       = in.jalr;
    ex.ALUSrcE     = in.alusrc;
    ex.MulDivE     = in.muldiv;
    ex.ResultSrcE  = in.rsrc;
    ex.ALUControlE = in.aluc;
    ex.funct3E     = in.f3;
    ex.rs1E        = in.rs1;
    ex.rs2E        = in.rs2;
    ex.ImmExtE     = in.imm;
    ex.PCE         = in.pc;
    ex.inc_PCE     = in.pc + 32'd4;
    ex.RdE         = in.rd;
    ex.ForwardAE   = in.fa;
    ex.ForwardBE   = in.fb;
    ex.ResultW     = in.resw;
  endtask

  task automatic check_redirect(input instr_t in, input logic [31:0] a, input logic [31:0] b, input logic stalled);
    logic [32:0] br;
    br = ref_branch(in, a, b);
    check32("StallE", {31'b0, ex.StallE}, {31'b0, stalled});
    check32("PCSrcE", {31'b0, ex.PCSrcE}, {31'b0, br[32] & ~stalled});
    check32("PCTargetE", ex.PCTargetE, br[31:0]);
  endtask

  task automatic do_reset();
    instr_t nop;
    nop = '0;
    @(negedge clk);
    apply(nop);
    rst = 1'b1;
    exp_q.push_back('0);
    m_alu = 32'd0;
  endtask

  task automatic issue(input instr_t in, input int abort_at);
    logic [31:0] a, wd, res;
    mrec_t       rec;
    instr_t      nop;
    nop = '0;
    @(negedge clk);
    apply(in);
    if (!(in.muldiv && in.f3[2])) begin
      a  = ref_fwd(in.rs1, in.fa, in.resw, m_alu);
      wd = ref_fwd(in.rs2, in.fb, in.resw, m_alu);
      res = in.muldiv ? ref_mul(in.f3, a, wd) : ref_alu(in.aluc, a, in.alusrc ? in.imm : wd);
      #1;
      check_redirect(in, a, wd, 1'b0);
      rec = {in.rw, in.mw, in.rsrc, res, wd, in.pc + 32'd4, in.f3, in.rd};
      exp_q.push_back(rec);
      m_alu = res;
    end else begin
      res = 32'd0;
      for (int c = 0; c < 34; c++) begin
        if (c > 0) begin
          @(negedge clk);
          ex.ResultW = $urandom;
        end
        if (c == abort_at) begin
          apply(nop);
          rst = 1'b1;
          exp_q.push_back('0);
          m_alu = 32'd0;
          return;
        end
        a  = ref_fwd(in.rs1, in.fa, ex.ResultW, m_alu);
        wd = ref_fwd(in.rs2, in.fb, ex.ResultW, m_alu);
        if (c == 0) res = ref_div(in.f3, a, wd);
        #1;
        if (c < 33) begin
          check_redirect(in, a, wd, 1'b1);
          exp_q.push_back('0);
          m_alu = 32'd0;
        end else begin
          check_redirect(in, a, wd, 1'b0);
          rec = {in.rw, in.mw, in.rsrc, res, wd, in.pc + 32'd4, in.f3, in.rd};
          exp_q.push_back(rec);
          m_alu = res;
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.rw     = 1'($urandom);
    t.mw     = 1'($urandom);
    t.jump   = ($urandom_range(0, 7) == 0);
    t.branch = 1'($urandom);
    t.jalr   = 1'($urandom);
    t.alusrc = 1'($urandom);
    t.muldiv = ($urandom_range(0, 3) == 0);
    t.rsrc   = 2'($urandom);
    t.aluc   = 4'($urandom);
    t.f3     = 3'($urandom);
    t.rs1    = rand_op();
    t.rs2    = rand_op();
    t.imm    = rand_op();
    t.pc     = {$urandom_range(0, 32'hFFFF), 2'b00};
    t.rd     = 5'($urandom);
    t.fa     = 2'($urandom);
    t.fb     = 2'($urandom);
    t.resw   = rand_op();
    return t;
  endfunction

  initial begin
    instr_t t;
    rst = 1'b1;
    t = '0;
    apply(t);
    rst = 1'b1;
    m_alu = 32'd0;
    do_reset();
    do_reset();

    // forwarding from ResultW into an add
    t = '0; t.rs1 = 32'd5; t.fa = 2'b01; t.resw = 32'd7; t.rs2 = 32'd3; t.rw = 1'b1; t.rd = 5'd3; t.pc = 32'h40;
    issue(t, -1);
    // blt taken / bltu not taken
    t = '0; t.branch = 1'b1; t.f3 = 3'b100; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1; t.pc = 32'h100; t.imm = 32'h20;
    issue(t, -1);
    t.f3 = 3'b110;
    issue(t, -1);
    // mulh
    t = '0; t.muldiv = 1'b1; t.f3 = 3'b001; t.rs1 = 32'h8000_0000; t.rs2 = 32'd2; t.rw = 1'b1; t.rd = 5'd9;
    issue(t, -1);
    // signed div and rem of -7 / 2
    t = '0; t.muldiv = 1'b1; t.f3 = 3'b100; t.rs1 = 32'hFFFF_FFF9; t.rs2 = 32'd2; t.rw = 1'b1; t.rd = 5'd4; t.pc = 32'h200;
    issue(t, -1);
    t.f3 = 3'b110;
    issue(t, -1);
    // divide-by-zero and overflow
    t = '0; t.muldiv = 1'b1; t.rw = 1'b1; t.rd = 5'd7; t.rs1 = 32'd9; t.rs2 = 32'd0;
    t.f3 = 3'b101; issue(t, -1);
    t.f3 = 3'b111; issue(t, -1);
    t.f3 = 3'b100; issue(t, -1);
    t.rs1 = 32'h8000_0000; t.rs2 = 32'hFFFF_FFFF; t.f3 = 3'b100;
    issue(t, -1);
    // reset during a divide, then a plain add
    t.rs1 = 32'd100; t.rs2 = 32'd7; t.f3 = 3'b100;
    issue(t, 10);
    t = '0; t.rs1 = 32'd20; t.rs2 = 32'd22; t.rw = 1'b1; t.rd = 5'd1;
    issue(t, -1);

    for (int i = 0; i < 200; i++) begin
      t = rand_instr();
      issue(t, -1);
    end

    repeat (3) @(negedge clk);
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RV32IM pipeline. It sits between the ID/EX register and the memory stage. It performs operand forwarding, ALU operations, branch/jump resolution and single-cycle multiply, and runs an iterative 32-cycle divider that stalls the front of the pipe. The EX/MEM pipeline register is internal, so every `*M` output is registered and feeds the memory stage directly.

## Interface
Parameters: none.

Ports:
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `JalrE`, `ALUSrcE`, `MulDivE` in 1 each: decoded controls.
- `ResultSrcE` in 2: writeback select, passed through.
- `ALUControlE` in 4: ALU operation (see Operation).
- `funct3E` in 3: branch condition / mul-div op / load-store size.
- `rs1E`, `rs2E` in 32: register-file read values.
- `ImmExtE`, `PCE`, `inc_PCE` in 32: immediate, PC, PC+4.
- `RdE` in 5: destination register.
- `ForwardAE`, `ForwardBE` in 2: forwarding selects: 00 = register value, 01 = `ResultW`, 10 = `ALUoutM`.
- `ResultW` in 32: writeback result.
- `PCSrcE` out 1: redirect fetch (combinational).
- `PCTargetE` out 32: redirect address (combinational).
- `StallE` out 1: divider busy; upstream holds IF/ID/EX (combinational).
- `RegWriteM`, `MemWriteM` out 1; `ResultSrcM` out 2; `ALUoutM`, `rs2M`, `inc_PCM` out 32; `funct3M` out 3; `RdM` out 5: EX/MEM register.

## Operation
- **Operand selection:**
  - SrcA = fwd(rs1E, ForwardAE).
  - WriteData = fwd(rs2E, ForwardBE).
  - SrcB = ALUSrcE ? ImmExtE : WriteData.
  - Forward select 11 behaves as 00.
- **ALUControlE codes:**
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra; shift amount is SrcB[4:0].
  - 1000 slt (signed), 1001 sltu.
  - 1010 pass SrcB (lui).
  - Any other code yields 0.
  - Arithmetic wraps modulo 2^32.
- **Branch and jump:**
  - Branch condition from funct3E, comparing SrcA against WriteData: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu. Codes 010 and 011 are never taken.
  - PCSrcE = JumpE | (BranchE & cond).
  - PCTargetE = JalrE ? ((SrcA + ImmExtE) & ~1) : (PCE + ImmExtE).
  - PCSrcE is forced to 0 while StallE = 1.
- **Multiply** (MulDivE = 1, funct3E[2] = 0), combinational, single cycle:
  - 000 mul: low 32 bits.
  - 001 mulh: s×s, high 32 bits.
  - 010 mulhsu: s×u, high 32 bits.
  - 011 mulhu: u×u, high 32 bits.
  - The 64-bit product uses 33-bit sign/zero-extended operands.
- **Divide** (MulDivE = 1, funct3E[2] = 1): 100 div, 101 divu, 110 rem, 111 remu.
  - FSM states IDLE, DIV, DONE.
  - IDLE → DIV when a divide is presented. Operands SrcA and WriteData are latched (absolute values for signed ops), along with the result sign flags. Iteration counter is cleared.
  - DIV: one restoring shift-subtract step per cycle; counter 0..31. After step 31 → DONE.
  - DONE: EX/MEM captures the result → IDLE.
  - Signed fix-up: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Divisor = 0: quotient = 0xFFFFFFFF, remainder = dividend. Applies to both signed and unsigned.
  - 0x80000000 / 0xFFFFFFFF (div): quotient 0x80000000, remainder 0.
- **StallE** = 1 in IDLE while a divide is presented, and throughout DIV. It is 0 in DONE.
- **EX/MEM register:**
  - Normal cycle: captures control, ALU/mul/div result → ALUoutM, WriteData → rs2M, funct3E, RdE, inc_PCE.
  - While StallE = 1: captures a bubble (RegWriteM = 0, MemWriteM = 0, RdM = 0; other fields 0).
- **Reset:** all EX/MEM outputs are 0, FSM goes to IDLE, counter is 0, StallE = 0. A reset during DIV aborts the divide with no result written.

## Timing
- ALU, multiply, branch and jump ops: 1-cycle latency; result in ALUoutM the cycle after presentation.
- Divide presented in cycle 0:
  - StallE high in cycles 0–32.
  - DONE in cycle 33; result appears in ALUoutM at cycle 34.
  - 33 bubbles are inserted into M.
- Forwarded values matter only in cycle 0 of a divide, since operands are latched then. Later ResultW/ALUoutM changes have no effect.
- Back-to-back divides: the second enters IDLE-detect in the cycle after DONE.

## Test plan
- **Forwarding:** rs1E = 5, ForwardAE = 01 with ResultW = 7, rs2E = 3, add → ALUoutM = 10 next cycle, RegWriteM follows RegWriteE.
- **Branch:** BranchE = 1, funct3E = 100, SrcA = 0xFFFFFFFF, WriteData = 1, PCE = 0x100, ImmExtE = 0x20 → PCSrcE = 1, PCTargetE = 0x120. Same with funct3E = 110 → PCSrcE = 0.
- **mulh:** 0x80000000 × 2 → ALUoutM = 0xFFFFFFFF after 1 cycle, StallE never high.
- **Signed divide:** div −7 / 2 → StallE high exactly 33 cycles, 33 bubbles (RegWriteM = 0), then ALUoutM = 0xFFFFFFFD. rem of the same operands → 0xFFFFFFFF.
- **Divide edge cases:** divu 9 / 0 → 0xFFFFFFFF. remu 9 / 0 → 9. div 0x80000000 / −1 → 0x80000000.
- **Reset mid-divide:** assert rst at cycle 10 of a divide → next cycle StallE = 0, all M outputs 0, FSM IDLE. A following add completes normally.
